// File: rtl/iir_coeff_loader_pkg.sv
// Shared types and constants for the biquad coefficient loader.
// Consumed by iir_coeff_loader (optional readback via COEFF_READBACK_EN).
package iir_coeff_pkg;

  typedef logic signed [15:0] coeff_t;

  typedef struct packed {
    coeff_t b0;
    coeff_t b1;
    coeff_t b2;
    coeff_t a1;
    coeff_t a2;
  } biquad_coeffs_t;

  localparam logic [3:0] ADDR_B0     = 4'h0;
  localparam logic [3:0] ADDR_B1     = 4'h1;
  localparam logic [3:0] ADDR_B2     = 4'h2;
  localparam logic [3:0] ADDR_A1     = 4'h3;
  localparam logic [3:0] ADDR_A2     = 4'h4;
  localparam logic [3:0] ADDR_COMMIT = 4'hF;

  localparam coeff_t Q2_14_ONE = 16'sh4000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } frame_state_e;

  function automatic coeff_t coeff_sel(input biquad_coeffs_t c, input logic [3:0] addr);
    case (addr)
      ADDR_B0: coeff_sel = c.b0;
      ADDR_B1: coeff_sel = c.b1;
      ADDR_B2: coeff_sel = c.b2;
      ADDR_A1: coeff_sel = c.a1;
      ADDR_A2: coeff_sel = c.a2;
      default: coeff_sel = '0;
    endcase
  endfunction

endpackage

// File: rtl/iir_coeff_loader_spi_sync_edge.sv
// Multi-stage synchronizer for the SPI pins with edge pulses on the
// synchronized sck and cs_n levels.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic sdi_i,
  output logic sdi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;

  // cs_n resets low so a frame already running at reset release yields no
  // falling edge; the loader waits for a fresh select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q      <= '0;
      cs_q       <= '0;
      sdi_q      <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
      cs_q       <= {cs_q[SYNC_STAGES-2:0], cs_n_i};
      sdi_q      <= {sdi_q[SYNC_STAGES-2:0], sdi_i};
      sck_prev_q <= sck_q[SYNC_STAGES-1];
      cs_prev_q  <= cs_q[SYNC_STAGES-1];
    end
  end

  assign sdi_o      = sdi_q[SYNC_STAGES-1];
  assign sck_rise_o =  sck_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[SYNC_STAGES-1] &  sck_prev_q;
  assign cs_fall_o  = ~cs_q[SYNC_STAGES-1]  &  cs_prev_q;
  assign cs_rise_o  =  cs_q[SYNC_STAGES-1]  & ~cs_prev_q;

endmodule

// File: rtl/iir_coeff_loader.sv
// SPI-slave shadow/active coefficient bank for iir_filter; a commit is applied
// on the next sample_tick. Define COEFF_READBACK_EN to enable sdo readback.
module iir_coeff_loader
  import iir_coeff_pkg::*;
#(
  parameter int     SYNC_STAGES = 2,
  parameter coeff_t RESET_B0    = Q2_14_ONE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sck,
  input  logic                cs_n,
  input  logic                sdi,
  output logic                sdo,
  input  logic                sample_tick,
  output logic signed [15:0]  b0,
  output logic signed [15:0]  b1,
  output logic signed [15:0]  b2,
  output logic signed [15:0]  a1,
  output logic signed [15:0]  a2,
  output logic                coeff_update,
  output logic                frame_err
);

  localparam biquad_coeffs_t RESET_SET = {RESET_B0, 64'h0};

  logic sdi_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sck_i     (sck),
    .cs_n_i    (cs_n),
    .sdi_i     (sdi),
    .sdi_o     (sdi_s),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .cs_fall_o (cs_fall),
    .cs_rise_o (cs_rise)
  );

  frame_state_e   state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [23:0]    shift_q, shift_d;
  biquad_coeffs_t shadow_q, shadow_d;
  biquad_coeffs_t active_q, active_d;
  logic           pending_q, pending_d;
  logic           update_q, update_d;
  logic           ferr_q, ferr_d;

  logic [23:0] shift_next;
  logic        bit_accept;
  logic        frame_done;
  logic        frm_rd;
  logic [3:0]  frm_addr;
  logic [15:0] frm_data;
  logic        commit_set;
  logic        wr_en;
  logic        transfer;

  assign shift_next = {shift_q[22:0], sdi_s};
  assign bit_accept = (state_q == ST_SHIFT) && !cs_rise && sck_rise;
  assign frame_done = bit_accept && (cnt_q == 5'd23);
  assign frm_rd     = shift_next[23];
  assign frm_addr   = shift_next[19:16];
  assign frm_data   = shift_next[15:0];
  assign commit_set = frame_done && (frm_addr == ADDR_COMMIT);
  assign wr_en      = frame_done && !frm_rd;
  assign transfer   = sample_tick && pending_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      shadow_q  <= RESET_SET;
      active_q  <= RESET_SET;
      pending_q <= 1'b0;
      update_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      update_q  <= update_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    update_d  = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          ferr_d  = (cnt_q != 5'd0);
        end else if (sck_rise) begin
          shift_d = shift_next;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd23) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The copy reads shadow_q, so a write landing on the tick cycle is deferred.
    if (transfer) begin
      active_d  = shadow_q;
      update_d  = 1'b1;
      pending_d = 1'b0;
    end
    if (commit_set) pending_d = 1'b1;

    if (wr_en) begin
      case (frm_addr)
        ADDR_B0: shadow_d.b0 = frm_data;
        ADDR_B1: shadow_d.b1 = frm_data;
        ADDR_B2: shadow_d.b2 = frm_data;
        ADDR_A1: shadow_d.a1 = frm_data;
        ADDR_A2: shadow_d.a2 = frm_data;
        default: ;
      endcase
    end
  end

`ifdef COEFF_READBACK_EN
  logic [15:0] rd_sreg_q, rd_sreg_d;
  logic        rd_act_q, rd_act_d;
  logic        hdr_done;

  assign hdr_done = bit_accept && (cnt_q == 5'd7);

  // Load at the end of the header; the falls after rising edges 9..23 walk
  // the remaining 15 bits onto sdo ahead of the master's sampling edges.
  always_comb begin
    rd_sreg_d = rd_sreg_q;
    rd_act_d  = rd_act_q;
    if (cs_rise || cs_fall) begin
      rd_act_d  = 1'b0;
      rd_sreg_d = '0;
    end else if (hdr_done) begin
      rd_act_d  = shift_next[7] && (shift_next[3:0] <= ADDR_A2);
      rd_sreg_d = coeff_sel(shadow_q, shift_next[3:0]);
    end else if (sck_fall && rd_act_q && (cnt_q >= 5'd9) && (cnt_q <= 5'd23)) begin
      rd_sreg_d = {rd_sreg_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sreg_q <= '0;
      rd_act_q  <= 1'b0;
    end else begin
      rd_sreg_q <= rd_sreg_d;
      rd_act_q  <= rd_act_d;
    end
  end

  assign sdo = rd_act_q & rd_sreg_q[15];
`else
  logic unused_sck_fall;
  assign unused_sck_fall = sck_fall;
  assign sdo             = 1'b0;
`endif

  assign b0           = active_q.b0;
  assign b1           = active_q.b1;
  assign b2           = active_q.b2;
  assign a1           = active_q.a1;
  assign a2           = active_q.a2;
  assign coeff_update = update_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader: a model of the shadow/active bank
// queues expected coefficient sets; a monitor records each coeff_update.
module tb_iir_coeff_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0;
  logic cs_n = 1'b1;
  logic sdi = 1'b0;
  logic sample_tick = 1'b0;
  logic sdo;
  logic coeff_update;
  logic frame_err;
  logic signed [15:0] b0, b1, b2, a1, a2;

  always #5 clk = ~clk;

  iir_coeff_loader #(
    .SYNC_STAGES(2),
    .RESET_B0   (16'sh4000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sck         (sck),
    .cs_n        (cs_n),
    .sdi         (sdi),
    .sdo         (sdo),
    .sample_tick (sample_tick),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .a1          (a1),
    .a2          (a2),
    .coeff_update(coeff_update),
    .frame_err   (frame_err)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] m_shadow [5];
  logic [15:0] m_active [5];
  bit          m_pending;
  logic [79:0] exp_q [$];

  logic [79:0] obs_arr [64];
  int          obs_wr = 0;
  int          obs_rd = 0;
  int          ferr_cnt = 0;

  always @(negedge clk) begin
    if (coeff_update === 1'b1) begin
      obs_arr[obs_wr[5:0]] <= {b0, b1, b2, a1, a2};
      obs_wr <= obs_wr + 1;
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_shadow  = '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0};
    m_active  = '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0};
    m_pending = 1'b0;
  endtask

  task automatic m_transfer();
    if (m_pending) begin
      m_active = m_shadow;
      exp_q.push_back({m_active[0], m_active[1], m_active[2], m_active[3], m_active[4]});
      m_pending = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample_tick = 1'b1;
    m_transfer();
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // One SPI mode-0 bit; optionally raise sample_tick in the cycle the rising
  // edge is detected (pin edge + 3 clk cycles with two sync stages).
  task automatic spi_bit(input logic b, input bit tick_here, output logic s);
    sdi = b;
    repeat (8) @(negedge clk);
    sck = 1'b1;
    if (tick_here) begin
      repeat (2) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    s = sdo;
    sck = 1'b0;
  endtask

  task automatic spi_frame(input logic [23:0] frm, input int nbits, input bit tick_last,
                           output logic [15:0] rd);
    logic s;
    rd = '0;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(frm[23-i], tick_last && (i == 23), s);
      if (i >= 8) rd = {rd[14:0], s};
    end
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic spi_write(input logic [3:0] addr, input logic [15:0] data, input bit tick_last);
    logic [15:0] rd;
    if (tick_last) m_transfer();
    spi_frame({1'b0, 3'b000, addr, data}, 24, tick_last, rd);
    if (addr <= 4'd4) m_shadow[int'(addr)] = data;
    if (addr == 4'hF) m_pending = 1'b1;
  endtask

  task automatic spi_read(input logic [3:0] addr, output logic [15:0] rd);
    spi_frame({1'b1, 3'b000, addr, 16'h0000}, 24, 1'b0, rd);
    if (addr == 4'hF) m_pending = 1'b1;
  endtask

  task automatic drain(input string tag);
    logic [79:0] e;
    int n_obs;
    repeat (3) @(negedge clk);
    n_obs = obs_wr - obs_rd;
    check_int({tag, "_update_count"}, n_obs, exp_q.size());
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front();
      checks++;
      assert (obs_arr[obs_rd[5:0]] === e) else begin
        errors++;
        $error("FAIL %s_set observed=%h expected=%h", tag, obs_arr[obs_rd[5:0]], e);
      end
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_wr;
  endtask

  initial begin
    logic [15:0] rd;
    logic        s;
    int          f0;
    logic [23:0] frm;

    m_reset();
    repeat (3) @(negedge clk);
    check16("rst_b0", b0, 16'h4000);
    check16("rst_b1", b1, 16'h0000);
    check16("rst_b2", b2, 16'h0000);
    check16("rst_a1", a1, 16'h0000);
    check16("rst_a2", a2, 16'h0000);
    check16("rst_update", {15'b0, coeff_update}, 16'h0);
    check16("rst_sdo", {15'b0, sdo}, 16'h0);
    check16("rst_ferr", {15'b0, frame_err}, 16'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Write then commit; outputs move only at T+1 of the tick.
    spi_write(4'h1, 16'h2000, 1'b0);
    spi_write(4'hF, 16'h0000, 1'b0);
    check16("b1_before_tick", b1, 16'h0000);
    tick();
    check16("update_at_T1", {15'b0, coeff_update}, 16'h1);
    check16("b1_at_T1", b1, 16'h2000);
    @(negedge clk);
    check16("update_one_cycle", {15'b0, coeff_update}, 16'h0);
    drain("commit1");

    // Write without commit must not reach the active set.
    spi_write(4'h3, 16'hC000, 1'b0);
    repeat (5) begin
      tick();
      repeat (3) @(negedge clk);
    end
    check16("a1_no_commit", a1, 16'h0000);
    drain("no_commit");
    spi_write(4'hF, 16'h0000, 1'b0);
    tick();
    drain("commit2");
    check16("a1_after_commit", a1, 16'hC000);

    // Short frame to b0.
    f0 = ferr_cnt;
    spi_frame({1'b0, 3'b000, 4'h0, 16'h1234}, 12, 1'b0, rd);
    check_int("short_frame_err", ferr_cnt, f0 + 1);
    spi_write(4'hF, 16'h0000, 1'b0);
    tick();
    drain("short");
    check16("b0_after_short", b0, 16'h4000);

    // Write landing on the tick cycle is excluded from that transfer.
    spi_write(4'h2, 16'h1000, 1'b0);
    spi_write(4'hF, 16'h0000, 1'b0);
    spi_write(4'h2, 16'h0800, 1'b1);
    drain("coincident");
    check16("b2_coincident", b2, 16'h1000);
    tick();
    tick();
    drain("pending_cleared");
    check16("b2_no_retransfer", b2, 16'h1000);
    spi_write(4'hF, 16'h0000, 1'b0);
    tick();
    drain("commit3");
    check16("b2_late", b2, 16'h0800);

    // Readback of a2; read must not disturb the shadow.
    spi_write(4'h4, 16'hA5C3, 1'b0);
    spi_read(4'h4, rd);
`ifdef COEFF_READBACK_EN
    check16("readback_a2", rd, 16'hA5C3);
`else
    check16("readback_a2", rd, 16'h0000);
`endif
    check16("sdo_idle", {15'b0, sdo}, 16'h0);
    spi_write(4'hF, 16'h0000, 1'b0);
    tick();
    drain("commit4");
    check16("a2_after_read", a2, 16'hA5C3);

    // Reset in the middle of a write frame to b0.
    frm = {1'b0, 3'b000, 4'h0, 16'h7777};
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) spi_bit(frm[23-i], 1'b0, s);
    reset = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    check16("midrst_b0", b0, 16'h4000);
    check16("midrst_b1", b1, 16'h0000);
    check16("midrst_update", {15'b0, coeff_update}, 16'h0);
    reset = 1'b0;
    f0 = ferr_cnt;
    for (int i = 10; i < 24; i++) spi_bit(frm[23-i], 1'b0, s);
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_int("midrst_no_ferr", ferr_cnt, f0);
    spi_write(4'h2, 16'h1234, 1'b0);
    spi_write(4'hF, 16'h0000, 1'b0);
    tick();
    drain("after_reset");
    check16("b2_after_reset", b2, 16'h1234);
    check16("b0_after_reset", b0, 16'h4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
